// File: rtl/mem_responder_if.sv
// mem_responder_if
//   Bus between the three-master arbiter side and the memory responder.
//   The master modport is the arbiter/command side. The slave modport is the
//   responder.
//   grant      : arbiter grant code (00 idle, 01 M1, 10 M2, 11 M3)
//   cmd_valid  : per-master command present, bit i = master i+1
//   cmd_we     : per-master write enable
//   cmd_addr   : per-master word address, slice [i*ADDR_W +: ADDR_W]
//   cmd_wdata  : per-master write data, sliced the same way
//   rdata      : read data, meaningful while rvalid is high
//   rvalid     : one-cycle read-data strobe
//   done       : one-hot one-cycle completion pulse to the owning master
//   busy       : responder is in ACCESS or RESP
//   perr       : read parity error, qualified by rvalid
interface mem_responder_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
);
  logic [1:0]          grant;
  logic [2:0]          cmd_valid;
  logic [2:0]          cmd_we;
  logic [3*ADDR_W-1:0] cmd_addr;
  logic [3*DATA_W-1:0] cmd_wdata;
  logic [DATA_W-1:0]   rdata;
  logic                rvalid;
  logic [2:0]          done;
  logic                busy;
  logic                perr;

  modport master (
    output grant, cmd_valid, cmd_we, cmd_addr, cmd_wdata,
    input  rdata, rvalid, done, busy, perr
  );

  modport slave (
    input  grant, cmd_valid, cmd_we, cmd_addr, cmd_wdata,
    output rdata, rvalid, done, busy, perr
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder
//   Memory-side responder for the three-master arbiter. Performs one
//   single-word read or write per granted command on an internal RAM of
//   2**ADDR_W words. It aborts without side effects if the grant is
//   withdrawn while the access is still in progress.
//   Optional feature macro: MEMRESP_PARITY_EN. When it is defined, each word
//   stores an even-parity bit and reads report a mismatch on perr. When it is
//   undefined, perr is tied to 0.
// Ports
//   clk    : clock, rising edge
//   reset  : asynchronous, active-high
//   bus    : mem_responder_if.slave (grant, cmd_*, rdata, rvalid, done, busy, perr)
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for a granted master with a valid command
//   ACCESS | command latched; write 1 cycle, read RD_LAT cycles
//   RESP   | one-cycle done pulse (+ rvalid for reads), back to IDLE
module mem_responder #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic           clk,
  input  logic           reset,
  mem_responder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [1:0] LAST_CNT = 2'(RD_LAT - 1);

  state_t              state;
  logic [1:0]          owner;
  logic [1:0]          cnt;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                rvalid_q;
  logic [2:0]          done_q;
  logic                busy_q;

  logic [DATA_W-1:0]   mem [2**ADDR_W];

  logic                sel_valid;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                grant_held;
  logic                last_cyc;
  logic                commit;
  logic                mem_wr;
  logic [2:0]          owner_oh;

  // Mux the granted master's command. Grant 00 selects nothing, so
  // sel_valid stays low and the responder remains idle.
  always_comb begin
    sel_valid = 1'b0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    case (bus.grant)
      2'd1: begin
        sel_valid = bus.cmd_valid[0];
        sel_we    = bus.cmd_we[0];
        sel_addr  = bus.cmd_addr[0 +: ADDR_W];
        sel_wdata = bus.cmd_wdata[0 +: DATA_W];
      end
      2'd2: begin
        sel_valid = bus.cmd_valid[1];
        sel_we    = bus.cmd_we[1];
        sel_addr  = bus.cmd_addr[ADDR_W +: ADDR_W];
        sel_wdata = bus.cmd_wdata[DATA_W +: DATA_W];
      end
      2'd3: begin
        sel_valid = bus.cmd_valid[2];
        sel_we    = bus.cmd_we[2];
        sel_addr  = bus.cmd_addr[2*ADDR_W +: ADDR_W];
        sel_wdata = bus.cmd_wdata[2*DATA_W +: DATA_W];
      end
      default: ;
    endcase
  end

  assign grant_held = (bus.grant == owner);
  assign last_cyc   = we_q || (cnt == LAST_CNT);
  assign commit     = (state == ACCESS) && grant_held && last_cyc;
  // Gating with reset drops a write whose commit edge coincides with reset.
  assign mem_wr     = commit && we_q && !reset;
  assign owner_oh   = {owner == 2'd3, owner == 2'd2, owner == 2'd1};

  // RAM contents are not reset.
  always_ff @(posedge clk) begin
    if (mem_wr) mem[addr_q] <= wdata_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= 2'd0;
      cnt      <= 2'd0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      done_q   <= 3'b000;
      busy_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_valid) begin
            owner   <= bus.grant;
            we_q    <= sel_we;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            cnt     <= 2'd0;
            busy_q  <= 1'b1;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (!grant_held) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end else if (last_cyc) begin
            done_q <= owner_oh;
            if (!we_q) begin
              rdata_q  <= mem[addr_q];
              rvalid_q <= 1'b1;
            end
            state <= RESP;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        RESP: begin
          done_q   <= 3'b000;
          rvalid_q <= 1'b0;
          busy_q   <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;
  assign bus.done   = done_q;
  assign bus.busy   = busy_q;

`ifdef MEMRESP_PARITY_EN
  logic par_mem [2**ADDR_W];
  logic perr_q;

  always_ff @(posedge clk) begin
    if (mem_wr) par_mem[addr_q] <= ^wdata_q;
  end

  // Registered on the same edge as rdata, so it drops with rvalid after RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) perr_q <= 1'b0;
    else       perr_q <= commit && !we_q && ((^mem[addr_q]) ^ par_mem[addr_q]);
  end

  assign bus.perr = perr_q;
`else
  assign bus.perr = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
//   Scoreboard bench for mem_responder. Expected responses are queued when a
//   command is issued and are popped when a done pulse is observed. Built with
//   RD_LAT=3 so that multi-cycle reads and mid-read preemption are exercised.
module tb_mem_responder;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;
  localparam int RD_LAT = 3;

  typedef struct packed {
    logic [2:0] done;
    logic       rv;
    logic [7:0] rdata;
    logic       perr;
  } exp_t;

  logic clk;
  logic reset;
  mem_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   n_chk  = 0;
  int   n_pass = 0;
  exp_t sb_q[$];
  logic [7:0] model_mem [64];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Scoreboard monitor samples outputs on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.done != 3'b000) begin
        if (sb_q.size() == 0) begin
          check_val("unexpected_done", 32'(bus.done), 32'd0);
        end else begin
          e = sb_q.pop_front();
          check_val("done", 32'(bus.done), 32'(e.done));
          check_val("rvalid", 32'(bus.rvalid), 32'(e.rv));
          if (e.rv) check_val("rdata", 32'(bus.rdata), 32'(e.rdata));
          check_val("perr", 32'(bus.perr), 32'(e.perr));
        end
      end else begin
        if (bus.rvalid) check_val("stray_rvalid", 32'(bus.rvalid), 32'd0);
        if (bus.perr)   check_val("stray_perr", 32'(bus.perr), 32'd0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_slice(input int m, input logic we, input int addr, input int wdata);
    bus.cmd_we[m-1]                    = we;
    bus.cmd_addr[(m-1)*ADDR_W +: ADDR_W] = ADDR_W'(addr);
    bus.cmd_wdata[(m-1)*DATA_W +: DATA_W] = DATA_W'(wdata);
  endtask

  task automatic push_exp(input int m, input logic we, input int addr, input int wdata, input logic perr);
    exp_t e;
    e.done  = 3'(1 << (m - 1));
    e.rv    = !we;
    e.rdata = we ? 8'h00 : model_mem[addr];
    e.perr  = perr;
    if (we) model_mem[addr] = 8'(wdata);
    sb_q.push_back(e);
  endtask

  // Issue one full command; called with the FSM idle, inputs changed #1 after a posedge.
  task automatic do_cmd(input int m, input logic we, input int addr, input int wdata, input logic perr);
    int n;
    bus.grant = 2'(m);
    set_slice(m, we, addr, wdata);
    bus.cmd_valid = 3'(1 << (m - 1));
    push_exp(m, we, addr, wdata, perr);
    @(posedge clk); #1;
    bus.cmd_valid = 3'b000;
    // Changing the command after capture must not affect the access.
    set_slice(m, !we, addr ^ 6'h2a, wdata ^ 8'hff);
    n = 0;
    while (bus.busy && n < 12) begin
      n++;
      @(posedge clk); #1;
    end
    check_val(we ? "busy_len_wr" : "busy_len_rd", 32'(n), we ? 32'd2 : 32'(RD_LAT + 1));
    bus.grant = 2'b00;
  endtask

  initial begin
    int n;
    reset         = 1'b1;
    bus.grant     = 2'b00;
    bus.cmd_valid = 3'b000;
    bus.cmd_we    = 3'b000;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    foreach (model_mem[i]) model_mem[i] = 8'h00;
    #12;
    check_val("rst_rdata", 32'(bus.rdata), 32'd0);
    check_val("rst_rvalid", 32'(bus.rvalid), 32'd0);
    check_val("rst_done", 32'(bus.done), 32'd0);
    check_val("rst_busy", 32'(bus.busy), 32'd0);
    check_val("rst_perr", 32'(bus.perr), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic write then read on M2, plus setup words.
    do_cmd(1, 1'b1, 9, 8'h00, 1'b0);
    do_cmd(2, 1'b1, 5, 8'hA5, 1'b0);
    do_cmd(2, 1'b0, 5, 0, 1'b0);

    // Grant without a command is ignored.
    bus.grant = 2'b11;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_val("nocmd_busy", 32'(bus.busy), 32'd0);
      check_val("nocmd_done", 32'(bus.done), 32'd0);
    end
    bus.grant = 2'b00;

    // M3 read preempted by M1 in the second ACCESS cycle.
    bus.grant = 2'b11;
    set_slice(3, 1'b0, 5, 0);
    bus.cmd_valid = 3'b100;
    @(posedge clk); #1;
    bus.cmd_valid = 3'b000;
    check_val("pre_busy_m3", 32'(bus.busy), 32'd1);
    @(posedge clk); #1;
    bus.grant = 2'b01;
    set_slice(1, 1'b1, 7, 8'h42);
    bus.cmd_valid = 3'b001;
    push_exp(1, 1'b1, 7, 8'h42, 1'b0);
    @(posedge clk); #1;
    check_val("abort_busy", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    check_val("m1_accept_busy", 32'(bus.busy), 32'd1);
    bus.cmd_valid = 3'b000;
    n = 1;
    while (bus.busy && n < 12) begin
      @(posedge clk); #1;
      if (bus.busy) n++;
    end
    check_val("m1_busy_len", 32'(n), 32'd2);
    bus.grant = 2'b00;
    do_cmd(1, 1'b0, 7, 0, 1'b0);

    // Write aborted in its only ACCESS cycle: RAM keeps the old value.
    bus.grant = 2'b10;
    set_slice(2, 1'b1, 9, 8'h3C);
    bus.cmd_valid = 3'b010;
    @(posedge clk); #1;
    bus.grant = 2'b00;
    bus.cmd_valid = 3'b000;
    @(posedge clk); #1;
    check_val("abort_wr_busy", 32'(bus.busy), 32'd0);
    do_cmd(2, 1'b0, 9, 0, 1'b0);

    // Reset during a read cancels it.
    bus.grant = 2'b01;
    set_slice(1, 1'b0, 5, 0);
    bus.cmd_valid = 3'b001;
    @(posedge clk); #1;
    bus.cmd_valid = 3'b000;
    @(posedge clk); #1;
    check_val("rst_mid_busy_before", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    #1;
    check_val("rst_mid_busy", 32'(bus.busy), 32'd0);
    check_val("rst_mid_done", 32'(bus.done), 32'd0);
    check_val("rst_mid_rvalid", 32'(bus.rvalid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_val("post_rst_busy", 32'(bus.busy), 32'd0);
    end
    bus.grant = 2'b00;
    do_cmd(1, 1'b0, 7, 0, 1'b0);

    // Parity: flip a stored bit when the feature is present.
    do_cmd(3, 1'b1, 2, 8'h0F, 1'b0);
`ifdef MEMRESP_PARITY_EN
    dut.par_mem[2] = ~dut.par_mem[2];
    do_cmd(3, 1'b0, 2, 0, 1'b1);
`else
    do_cmd(3, 1'b0, 2, 0, 1'b0);
`endif

    // Random traffic over a pre-written address window.
    for (int a = 16; a < 24; a++) do_cmd(int'($urandom_range(1, 3)), 1'b1, a, int'($urandom_range(0, 255)), 1'b0);
    for (int i = 0; i < 16; i++) begin
      do_cmd(int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), int'($urandom_range(16, 23)),
             int'($urandom_range(0, 255)), 1'b0);
    end

    repeat (3) @(posedge clk);
    #1;
    check_val("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
